// File: rtl/lsu.sv
// Memory-access stage: issues one data-bus transaction per load/store,
// forwards the execute result otherwise, and hands the result to write-back.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   E_valid_i / m_ready_o : handshake with the execute stage
//   is_load_i, is_store_i, funct3_i, res_i, wdata_i : executed instruction
//   req_*                 : bus request channel (valid/ready)
//   resp_*                : bus response channel (valid/ready)
//   m_valid_o / W_ready_i : handshake with write-back; res_o, err_o payload
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            E_valid_i,
  output logic            m_ready_o,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] res_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic            req_we_o,
  output logic [XLEN-1:0] req_addr_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [3:0]      req_wstrb_o,
  input  logic            resp_valid_i,
  input  logic [XLEN-1:0] resp_rdata_i,
  input  logic            resp_err_i,
  output logic            resp_ready_o,
  output logic            m_valid_o,
  input  logic            W_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e            state_q;
  logic              m_valid_q;
  logic              req_valid_q;
  logic              resp_ready_q;
  logic              we_q;
  logic              ld_q;
  logic [2:0]        f3_q;
  logic [3:0]        wstrb_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   res_q;
  logic              err_q;

  logic              accept;
  logic              mem_op;
  logic              misal;
  logic [3:0]        wstrb_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ld_d;

  assign m_ready_o = (state_q == IDLE) |
                     ((state_q == DONE) & W_ready_i);
  assign accept    = E_valid_i & m_ready_o;
  assign mem_op    = is_load_i | is_store_i;

  always_comb begin
    misal = 1'b1;
    case (funct3_i[1:0])
      2'b00:   misal = 1'b0;
      2'b01:   misal = res_i[0];
      2'b10:   misal = |res_i[1:0];
      default: misal = 1'b1;
    endcase
  end

  // Strobes are zero for anything that is not a bus write.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << res_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << res_i[1:0];
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!is_store_i || misal)
      wstrb_d = 4'b0000;
  end

  // Read data is word-lane aligned; shift the addressed byte down to bit 0.
  assign sh = resp_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_d = sh;
    case (f3_q)
      3'b000:  ld_d = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  ld_d = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  ld_d = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  ld_d = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: ld_d = sh;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      m_valid_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      we_q         <= 1'b0;
      ld_q         <= 1'b0;
      f3_q         <= 3'b000;
      wstrb_q      <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            ld_q    <= is_load_i;
            f3_q    <= funct3_i;
            addr_q  <= res_i;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= is_store_i & ~misal;
            if (!mem_op) begin
              state_q   <= DONE;
              m_valid_q <= 1'b1;
              res_q     <= res_i;
              err_q     <= 1'b0;
            end else if (misal) begin
              state_q   <= DONE;
              m_valid_q <= 1'b1;
              res_q     <= '0;
              err_q     <= 1'b1;
            end else begin
              state_q     <= REQ;
              m_valid_q   <= 1'b0;
              req_valid_q <= 1'b1;
              res_q       <= res_i;
              err_q       <= 1'b0;
            end
          end else if (state_q == DONE && W_ready_i) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
          end
        end
        REQ: begin
          if (req_ready_i) begin
            state_q      <= RESP;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        RESP: begin
          if (resp_valid_i) begin
            state_q      <= DONE;
            resp_ready_q <= 1'b0;
            m_valid_q    <= 1'b1;
            if (resp_err_i) begin
              res_q <= '0;
              err_q <= 1'b1;
            end else if (ld_q) begin
              res_q <= ld_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid_o  = req_valid_q;
  assign req_we_o     = we_q;
  assign req_addr_o   = addr_q;
  assign req_wdata_o  = wdata_q;
  assign req_wstrb_o  = wstrb_q;
  assign resp_ready_o = resp_ready_q;
  assign m_valid_o    = m_valid_q;
  assign res_o        = res_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized
// loads/stores/ALU ops against a byte-level reference model.
module tb_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        E_valid_i;
  logic        m_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] res_i;
  logic [31:0] wdata_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wstrb_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic        resp_err_i;
  logic        resp_ready_o;
  logic        m_valid_o;
  logic        W_ready_i;
  logic [31:0] res_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  lsu dut (
    .clock        (clock),
    .reset        (reset),
    .E_valid_i    (E_valid_i),
    .m_ready_o    (m_ready_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .res_i        (res_i),
    .wdata_i      (wdata_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_we_o     (req_we_o),
    .req_addr_o   (req_addr_o),
    .req_wdata_o  (req_wdata_o),
    .req_wstrb_o  (req_wstrb_o),
    .resp_valid_i (resp_valid_i),
    .resp_rdata_i (resp_rdata_i),
    .resp_err_i   (resp_err_i),
    .resp_ready_o (resp_ready_o),
    .m_valid_o    (m_valid_o),
    .W_ready_i    (W_ready_i),
    .res_o        (res_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access size in bytes, lane by lane, plain arithmetic.
  task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input bit berr,
                       output bit bus, output logic [3:0] strb,
                       output logic [31:0] wdx, output logic [31:0] res,
                       output bit err);
    int sz;
    int a;
    logic [31:0] v;
    a = int'(addr[1:0]);
    case (f3[1:0])
      2'd0: sz = 1;
      2'd1: sz = 2;
      2'd2: sz = 4;
      default: sz = 0;
    endcase
    strb = 4'b0;
    wdx = 32'b0;
    for (int i = 0; i < 4; i++)
      wdx[8*i +: 8] = wd[8*(i % (sz == 0 ? 1 : sz)) +: 8];
    if (!ld && !st) begin
      bus = 0; res = addr; err = 0;
    end else if (sz == 0 || (a % sz) != 0) begin
      bus = 0; res = 0; err = 1;
    end else begin
      bus = 1;
      for (int i = 0; i < 4; i++)
        strb[i] = st && (i >= a) && (i < a + sz);
      if (berr) begin
        res = 0; err = 1;
      end else if (st) begin
        res = addr; err = 0;
      end else begin
        v = 0;
        for (int j = 0; j < sz; j++)
          v[8*j +: 8] = rd[8*(a+j) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1])
          for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
        res = v; err = 0;
      end
    end
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input bit berr,
                       input int rqd, input int rsd, input int hold);
    bit bus;
    bit err;
    logic [3:0] strb;
    logic [31:0] wdx;
    logic [31:0] res;
    model(ld, st, f3, addr, wd, rd, berr, bus, strb, wdx, res, err);
    @(negedge clock);
    chk("m_ready_idle", {31'b0, m_ready_o}, 32'd1);
    E_valid_i = 1; is_load_i = ld; is_store_i = st;
    funct3_i = f3; res_i = addr; wdata_i = wd;
    @(negedge clock);
    E_valid_i = 0; is_load_i = 0; is_store_i = 0;
    res_i = $urandom; wdata_i = $urandom;
    if (bus) begin
      for (int k = 0; k <= rqd; k++) begin
        chk("req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("req_we", {31'b0, req_we_o}, {31'b0, st});
        chk("req_addr", req_addr_o, addr);
        chk("req_wstrb", {28'b0, req_wstrb_o}, {28'b0, strb});
        if (st) chk("req_wdata", req_wdata_o, wdx);
        chk("m_valid_req", {31'b0, m_valid_o}, 32'd0);
        if (k < rqd) @(negedge clock);
      end
      req_ready_i = 1;
      @(negedge clock);
      req_ready_i = 0;
      chk("req_drop", {31'b0, req_valid_o}, 32'd0);
      for (int k = 0; k < rsd; k++) begin
        chk("resp_ready", {31'b0, resp_ready_o}, 32'd1);
        @(negedge clock);
      end
      chk("resp_ready", {31'b0, resp_ready_o}, 32'd1);
      resp_valid_i = 1; resp_rdata_i = rd; resp_err_i = berr;
      @(negedge clock);
      resp_valid_i = 0; resp_err_i = 0; resp_rdata_i = $urandom;
      chk("resp_ready_drop", {31'b0, resp_ready_o}, 32'd0);
    end else begin
      chk("no_req", {31'b0, req_valid_o}, 32'd0);
    end
    for (int k = 0; k <= hold; k++) begin
      chk("m_valid", {31'b0, m_valid_o}, 32'd1);
      chk("res", res_o, res);
      chk("err", {31'b0, err_o}, {31'b0, err});
      if (k < hold) @(negedge clock);
    end
    W_ready_i = 1;
    @(negedge clock);
    W_ready_i = 0;
    chk("m_valid_fall", {31'b0, m_valid_o}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3tab [6];
    int kind;
    logic [31:0] v;
    f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b010;
    f3tab[3] = 3'b100; f3tab[4] = 3'b101; f3tab[5] = 3'b011;
    reset = 1; E_valid_i = 0; is_load_i = 0; is_store_i = 0;
    funct3_i = 0; res_i = 0; wdata_i = 0; req_ready_i = 0;
    resp_valid_i = 0; resp_rdata_i = 0; resp_err_i = 0; W_ready_i = 0;
    repeat (2) @(negedge clock);
    chk("rst_m_valid", {31'b0, m_valid_o}, 32'd0);
    chk("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
    chk("rst_resp_ready", {31'b0, resp_ready_o}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_we_strb", {27'b0, req_we_o, req_wstrb_o}, 32'd0);
    reset = 0;

    // Non-memory first op then a back-to-back stream.
    E_valid_i = 1; res_i = 32'h1234; W_ready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      v = res_i;
      @(negedge clock);
      chk("alu_valid", {31'b0, m_valid_o}, 32'd1);
      chk("alu_res", res_o, v);
      chk("alu_ready", {31'b0, m_ready_o}, 32'd1);
      res_i = 32'h1000 * i + $urandom_range(0, 255);
    end
    E_valid_i = 0;
    @(negedge clock);
    chk("alu_drain", {31'b0, m_valid_o}, 32'd0);
    W_ready_i = 0;

    do_op(0, 1, 3'b000, 32'h80000003, 32'hAB, 0, 0, 3, 1, 0);
    do_op(1, 0, 3'b000, 32'h00000101, 0, 32'h0000F000, 0, 0, 0, 0);
    do_op(1, 0, 3'b100, 32'h00000101, 0, 32'h0000F000, 0, 1, 0, 0);
    do_op(1, 0, 3'b001, 32'h00000102, 0, 32'h80000000, 0, 0, 2, 0);
    do_op(1, 0, 3'b010, 32'h00000102, 0, 0, 0, 0, 0, 0);
    do_op(0, 1, 3'b001, 32'h00000101, 32'h5555, 0, 0, 0, 0, 0);
    do_op(1, 0, 3'b010, 32'h00000100, 0, 32'hDEADBEEF, 1, 0, 0, 5);

    // Reset while waiting for a response.
    @(negedge clock);
    E_valid_i = 1; is_load_i = 1; funct3_i = 3'b010; res_i = 32'h40;
    @(negedge clock);
    E_valid_i = 0; is_load_i = 0; req_ready_i = 1;
    @(negedge clock);
    req_ready_i = 0;
    chk("mid_resp_ready", {31'b0, resp_ready_o}, 32'd1);
    reset = 1;
    @(negedge clock);
    reset = 0; resp_valid_i = 1; resp_rdata_i = 32'h77;
    @(negedge clock);
    chk("late_resp_ready", {31'b0, resp_ready_o}, 32'd0);
    chk("late_m_valid", {31'b0, m_valid_o}, 32'd0);
    chk("late_m_ready", {31'b0, m_ready_o}, 32'd1);
    @(negedge clock);
    resp_valid_i = 0;
    chk("late_m_valid2", {31'b0, m_valid_o}, 32'd0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      do_op(kind == 0, kind == 1, f3tab[$urandom_range(0, 5)],
            $urandom, $urandom, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access (M) stage placed directly downstream of the execute unit.
- Takes an executed instruction from the E→M handshake. For loads and stores it issues one transaction on a simple request/response data bus; for all other instructions it forwards the execute result.
- Presents the registered result to the write-back (W) stage through a valid/ready handshake.
- Handles byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and bus errors.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- E_valid_i  in  1  execute output valid (from E stage).
- m_ready_o  out  1  LSU can accept (to E stage).
- is_load_i  in  1  instruction is a load.
- is_store_i  in  1  instruction is a store.
- funct3_i  in  3  access size/sign (RV32 load/store funct3).
- res_i  in  XLEN  execute result; used as the effective address for loads/stores.
- wdata_i  in  XLEN  store data (rs2 value).
- req_valid_o  out  1  bus request valid.
- req_ready_i  in  1  bus accepts request.
- req_we_o  out  1  1 = write, 0 = read.
- req_addr_o  out  XLEN  byte address of the access.
- req_wdata_o  out  XLEN  lane-aligned write data.
- req_wstrb_o  out  4  byte write strobes; 0 for reads.
- resp_valid_i  in  1  bus response valid.
- resp_rdata_i  in  XLEN  read data, word-lane aligned.
- resp_err_i  in  1  bus error on this response.
- resp_ready_o  out  1  LSU accepts response.
- m_valid_o  out  1  result valid (to W stage).
- W_ready_i  in  1  W stage accepts the result.
- res_o  out  XLEN  result: extended load data, otherwise res_i.
- err_o  out  1  access fault: misaligned access or bus error.

Behaviour:
- The clock and reset ports are named clock and reset, as elsewhere in the codebase. There is one clock; reset is synchronous and active-high.
- FSM states: IDLE, REQ, RESP, DONE.
- Reset values: state=IDLE, m_valid_o=0, req_valid_o=0, resp_ready_o=0, res_o=0, err_o=0, req_we_o=0, req_wstrb_o=0.
- Reset mid-transaction returns the FSM to IDLE. A late bus response is then ignored, because resp_ready_o=0.
- Handshake rule: m_ready_o = (state==IDLE) | (state==DONE & W_ready_i). An accept occurs when E_valid_i & m_ready_o.
- On accept, all inputs are captured into internal registers. Bus outputs are driven only from those registers, so they stay stable while req_valid_o=1 and req_ready_i=0.
- Non-memory instruction (neither load nor store): on accept, go to DONE with res_o=res_i and err_o=0. Latency is 1 cycle.
- Misalignment check:
  - Halfword (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (10) with addr[1:0]≠0 is misaligned.
  - funct3[1:0]=11 is treated as misaligned.
  - A misaligned load/store issues no bus request: go to DONE with err_o=1, res_o=0.
- Aligned load/store: go to REQ.
  - REQ: req_valid_o=1. When req_ready_i=1, go to RESP; req_valid_o drops the next cycle.
  - RESP: resp_ready_o=1. When resp_valid_i=1, go to DONE.
  - The bus never responds in the same cycle as the request handshake. A resp_valid_i seen outside RESP is ignored.
- Store lanes (a = addr[1:0]):
  - SB: wstrb = 4'b0001<<a; wdata = {4{wdata_i[7:0]}}.
  - SH: wstrb = 4'b0011<<a; wdata = {2{wdata_i[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = wdata_i.
- Load extraction: d = resp_rdata_i >> (8*a).
  - LB: sext(d[7:0]). LH: sext(d[15:0]). LW: d.
  - LBU: zext(d[7:0]). LHU: zext(d[15:0]).
- Bus error: resp_err_i=1 in RESP gives err_o=1, res_o=0.
- Store result: res_o=res_i, err_o=0 unless a fault occurred.
- DONE:
  - m_valid_o=1, and res_o/err_o are held stable until W_ready_i.
  - On W_ready_i with a simultaneous new accept, the FSM goes directly to the next instruction's state (DONE or REQ). This sustains 1 instruction/cycle for non-memory ops.
  - On W_ready_i with no accept, go to IDLE and m_valid_o falls the next cycle.
- m_valid_o is 1 only in DONE. req_valid_o is 1 only in REQ. resp_ready_o is 1 only in RESP.

Test Plan:
- Reset / non-memory: hold reset 2 cycles → all outputs 0. Then E_valid_i=1 with a non-memory op, res_i=0x1234 → next cycle m_valid_o=1, res_o=0x1234. With W_ready_i=1 and E_valid_i held, stream 4 ALU ops → 1 result per cycle in order.
- SB lane: SB with res_i=0x80000003, wdata_i=0xAB → req_we_o=1, req_wstrb_o=0x8, req_wdata_o=0xABABABAB. Hold req_ready_i=0 for 3 cycles → request stable. Response 2 cycles after the handshake → m_valid_o=1, err_o=0.
- Load extension: LB at addr=0x...01 with rdata 0x0000F000 → res_o=0xFFFFFFF0. LBU at the same address and data → 0x000000F0. LH at addr 0x...02 with rdata 0x80000000 → 0xFFFF8000.
- Misaligned: LW at addr 0x...02 → no req_valid_o; next cycle m_valid_o=1, err_o=1, res_o=0. SH at addr 0x...01 → same response.
- Bus error: LW with resp_err_i=1 → err_o=1, res_o=0. W_ready_i=0 for 5 cycles → m_valid_o, res_o and err_o all held.
- Reset mid-operation: assert reset while in RESP; afterwards drive resp_valid_i=1 → resp_ready_o=0, m_valid_o stays 0, state IDLE, m_ready_o=1.
